// File: rtl/soc_evt_link_tx.sv
// rtl/soc_evt_link_tx.sv - multi-source event transmitter onto the token-ring cluster event link
// Optional SOC_EVT_LINK_DROP_EN: saturated sources are still acked, the event is dropped and ovf_o flags it.
module soc_evt_link_tx #(
  parameter int N_SRC        = 4,
  parameter int BUFFER_WIDTH = 8,
  parameter int EVNT_WIDTH   = 8,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [N_SRC-1:0]                   src_valid_i,
  output logic [N_SRC-1:0]                   src_ack_o,
  output logic [BUFFER_WIDTH-1:0]            evt_wt_o,
  input  logic [BUFFER_WIDTH-1:0]            evt_rp_i,
  output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] evt_da_o,
  output logic                               full_o,
  output logic [N_SRC-1:0]                   ovf_o
);

  localparam int                      IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]        LAST_RST = IDX_W'(N_SRC - 1);
  localparam logic [BUFFER_WIDTH-1:0] TOK_RST  = BUFFER_WIDTH'(1);

  logic [BUFFER_WIDTH-1:0] rp_meta;
  logic [BUFFER_WIDTH-1:0] rp_sync;
  logic [BUFFER_WIDTH-1:0] wt_rot;
  logic [CNT_WIDTH-1:0]    cnt [N_SRC];
  logic [IDX_W-1:0]        last_gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic [IDX_W-1:0]        cand;
  logic                    gnt_found;
  logic                    gnt;
  logic [N_SRC-1:0]        ack_set;
  logic [N_SRC-1:0]        inc;
  logic [N_SRC-1:0]        dec;

  // The cluster read pointer lives in another clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rp_meta <= TOK_RST;
      rp_sync <= TOK_RST;
    end else begin
      rp_meta <= evt_rp_i;
      rp_sync <= rp_meta;
    end
  end

  // Full leaves one slot unused so token == pointer can only mean empty.
  assign wt_rot = {evt_wt_o[BUFFER_WIDTH-2:0], evt_wt_o[BUFFER_WIDTH-1]};
  assign full_o = |(wt_rot & rp_sync);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = IDX_W'((int'(last_gnt) + 1 + k) % N_SRC);
      if (!gnt_found && cnt[cand] != '0) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt = gnt_found & ~full_o;

`ifdef SOC_EVT_LINK_DROP_EN
  logic [N_SRC-1:0] ovf_set;
  logic [N_SRC-1:0] ovf_q;

  always_comb begin
    ack_set = '0;
    inc     = '0;
    ovf_set = '0;
    dec     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_set[i] = src_valid_i[i] & ~src_ack_o[i];
      inc[i]     = ack_set[i] & (cnt[i] != CNT_MAX);
      ovf_set[i] = ack_set[i] & (cnt[i] == CNT_MAX);
      dec[i]     = gnt & (gnt_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
    end
  end

  assign ovf_o = ovf_q;
`else
  // Saturated counters withhold the ack, back-pressuring the source.
  always_comb begin
    ack_set = '0;
    inc     = '0;
    dec     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_set[i] = src_valid_i[i] & ~src_ack_o[i] & (cnt[i] != CNT_MAX);
      inc[i]     = ack_set[i];
      dec[i]     = gnt & (gnt_idx == IDX_W'(i));
    end
  end

  assign ovf_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_SRC; i++) begin
        cnt[i] <= '0;
      end
      src_ack_o <= '0;
      last_gnt  <= LAST_RST;
    end else begin
      src_ack_o <= ack_set;
      for (int i = 0; i < N_SRC; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end else if (dec[i] && !inc[i]) begin
          cnt[i] <= cnt[i] - CNT_WIDTH'(1);
        end
      end
      if (gnt) begin
        last_gnt <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_wt_o <= TOK_RST;
      evt_da_o <= '0;
    end else if (gnt) begin
      for (int k = 0; k < BUFFER_WIDTH; k++) begin
        if (evt_wt_o[k]) begin
          evt_da_o[k*EVNT_WIDTH +: EVNT_WIDTH] <= EVNT_WIDTH'(gnt_idx);
        end
      end
      evt_wt_o <= wt_rot;
    end
  end

endmodule

// File: tb/tb_soc_evt_link_tx.sv
// tb/tb_soc_evt_link_tx.sv - scoreboard bench for soc_evt_link_tx
`timescale 1ns/1ps
module tb_soc_evt_link_tx;
  localparam int N_SRC = 4;
  localparam int BW    = 8;
  localparam int EW    = 8;
  localparam int CW    = 3;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_SRC-1:0] src_valid = '0;
  logic [N_SRC-1:0] src_ack;
  logic [N_SRC-1:0] ovf;
  logic [BW-1:0]    wt;
  logic [BW-1:0]    rp = 8'h01;
  logic [BW*EW-1:0] da;
  logic             full;

  int               n_chk = 0;
  int               n_pass = 0;
  logic [EW-1:0]    sb_q [$];
  int               req_tot  [N_SRC] = '{default: 0};
  int               req_done [N_SRC] = '{default: 0};
  int               ack_cnt  [N_SRC] = '{default: 0};
  int               wr_cnt = 0;
  bit               drain = 1'b0;
  logic [BW-1:0]    rp_hold = 8'h01;
  logic [BW-1:0]    prev_wt = 8'h01;

  soc_evt_link_tx #(
    .N_SRC(N_SRC), .BUFFER_WIDTH(BW), .EVNT_WIDTH(EW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_valid_i(src_valid), .src_ack_o(src_ack),
    .evt_wt_o(wt), .evt_rp_i(rp), .evt_da_o(da), .full_o(full), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [BW-1:0] rotl(input logic [BW-1:0] v);
    return {v[BW-2:0], v[BW-1]};
  endfunction

  // Sources: raise valid for each queued request, drop it once acked.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      src_valid = '0;
      for (int i = 0; i < N_SRC; i++) req_done[i] = req_tot[i];
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (src_ack[i]) src_valid[i] = 1'b0;
        else if (!src_valid[i] && req_done[i] < req_tot[i]) begin
          src_valid[i] = 1'b1;
          req_done[i]++;
        end
      end
    end
    rp = drain ? wt : rp_hold;
  end

  // Every token move is one ring write; compare the written slot with the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) prev_wt = 8'h01;
    else begin
      for (int i = 0; i < N_SRC; i++) if (src_ack[i]) ack_cnt[i]++;
      if (wt !== prev_wt) begin
        int slot;
        slot = 0;
        wr_cnt++;
        for (int k = 0; k < BW; k++) if (prev_wt[k]) slot = k;
        check("wt_rotate", 64'(wt), 64'(rotl(prev_wt)));
        if (sb_q.size() == 0) check("sb_unexpected_write", 64'(1), 64'(0));
        else check("slot_data", 64'(da[slot*EW +: EW]), 64'(sb_q.pop_front()));
        prev_wt = wt;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int wb, ab, dropped;
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wt", 64'(wt), 64'h01);
    check("rst_da", 64'(da), 64'h0);
    check("rst_ack", 64'(src_ack), 64'h0);
    check("rst_full", 64'(full), 64'h0);
    check("rst_ovf", 64'(ovf), 64'h0);
    @(posedge clk); #3 rst_n = 1'b1;

    // Single event from source 2
    drain = 1'b1;
    @(posedge clk); #3;
    req_tot[2]++; sb_q.push_back(8'h02);
    @(posedge clk); #3;
    @(negedge clk);
    check("single_c0_ack", 64'(src_ack[2]), 64'h0);
    @(negedge clk);
    check("single_c1_ack", 64'(src_ack[2]), 64'h1);
    check("single_c1_wt", 64'(wt), 64'h01);
    @(negedge clk);
    check("single_c2_wt", 64'(wt), 64'h02);
    check("single_c2_slot0", 64'(da[7:0]), 64'h02);
    repeat (5) @(negedge clk);

    // Round-robin from reset, then sources 1 and 3 with last_gnt = 3
    do_reset();
    @(posedge clk); #3;
    for (int i = 0; i < N_SRC; i++) begin req_tot[i]++; sb_q.push_back(EW'(i)); end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) check("rr_slot", 64'(da[i*EW +: EW]), 64'(i));
    check("rr_wt", 64'(wt), 64'h10);
    @(posedge clk); #3;
    req_tot[1]++; req_tot[3]++;
    sb_q.push_back(8'h01); sb_q.push_back(8'h03);
    repeat (10) @(negedge clk);
    check("rr2_slot4", 64'(da[4*EW +: EW]), 64'h01);
    check("rr2_slot5", 64'(da[5*EW +: EW]), 64'h03);
    check("rr2_wt", 64'(wt), 64'h40);

    // Full: reader parked at slot 0
    drain = 1'b0; rp_hold = 8'h01;
    do_reset();
    @(posedge clk); #3;
    wb = wr_cnt; ab = ack_cnt[0];
    req_tot[0] += 10;
    for (int i = 0; i < 10; i++) sb_q.push_back(8'h00);
    repeat (40) @(negedge clk);
    check("full_writes", 64'(wr_cnt - wb), 64'd7);
    check("full_flag", 64'(full), 64'h1);
    check("full_wt", 64'(wt), 64'h80);
    check("full_acks", 64'(ack_cnt[0] - ab), 64'd10);
    @(posedge clk); #3 rp_hold = 8'h02;
    @(posedge clk); #2;
    dropped = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (!full) dropped = 1;
    end
    check("full_drop_3cyc", 64'(dropped), 64'h1);
    repeat (5) @(negedge clk);
    check("wrap_wt", 64'(wt), 64'h01);
    check("wrap_writes", 64'(wr_cnt - wb), 64'd8);
    check("wrap_full_again", 64'(full), 64'h1);
    drain = 1'b1;
    repeat (20) @(negedge clk);
    check("full_all_writes", 64'(wr_cnt - wb), 64'd10);
    check("full_sb_empty", 64'(sb_q.size()), 64'd0);

    // Saturation on source 1 with a full ring
    drain = 1'b0; rp_hold = 8'h01;
    do_reset();
    @(posedge clk); #3;
    req_tot[0] += 7;
    for (int i = 0; i < 7; i++) sb_q.push_back(8'h00);
    repeat (25) @(negedge clk);
    check("sat_ring_full", 64'(full), 64'h1);
    @(posedge clk); #3;
    wb = wr_cnt; ab = ack_cnt[1];
    req_tot[1] += 9;
`ifdef SOC_EVT_LINK_DROP_EN
    for (int i = 0; i < 7; i++) sb_q.push_back(8'h01);
    repeat (30) @(negedge clk);
    check("sat_acks", 64'(ack_cnt[1] - ab), 64'd9);
    check("sat_ovf", 64'(ovf), 64'h2);
    drain = 1'b1;
    repeat (40) @(negedge clk);
    check("sat_drained_writes", 64'(wr_cnt - wb), 64'd7);
`else
    for (int i = 0; i < 9; i++) sb_q.push_back(8'h01);
    repeat (30) @(negedge clk);
    check("sat_acks", 64'(ack_cnt[1] - ab), 64'd7);
    check("sat_ack_withheld", 64'(src_ack[1]), 64'h0);
    @(posedge clk); #3 rp_hold = 8'h02;
    repeat (10) @(negedge clk);
    check("sat_one_grant", 64'(wr_cnt - wb), 64'd1);
    check("sat_acks_after_grant", 64'(ack_cnt[1] - ab), 64'd8);
    drain = 1'b1;
    repeat (40) @(negedge clk);
    check("sat_all_acks", 64'(ack_cnt[1] - ab), 64'd9);
    check("sat_drained_writes", 64'(wr_cnt - wb), 64'd9);
    check("sat_ovf", 64'(ovf), 64'h0);
`endif
    check("sat_sb_empty", 64'(sb_q.size()), 64'd0);

    // Reset mid-stream while source 2 has a pending count
    drain = 1'b1;
    do_reset();
    @(posedge clk); #3;
    req_tot[2] += 5;
    for (int i = 0; i < 5; i++) sb_q.push_back(8'h02);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (src_ack[2]) seen = 1'b1;
    end
    check("mid_ack_seen", 64'(seen), 64'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wt", 64'(wt), 64'h01);
    check("mid_rst_da", 64'(da), 64'h0);
    check("mid_rst_ack", 64'(src_ack), 64'h0);
    check("mid_rst_full", 64'(full), 64'h0);
    check("mid_rst_ovf", 64'(ovf), 64'h0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wb = wr_cnt;
    repeat (20) @(negedge clk);
    check("mid_no_writes", 64'(wr_cnt - wb), 64'd0);
    check("mid_wt_idle", 64'(wt), 64'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
